// File: rtl/sipo_universal_shift_reg_pkg.sv
// Shared constants and helpers for the universal SIPO shift register.
// Direction encodings and the bit-counter width function live here.
package sipo_pkg;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/sipo_universal_shift_reg_if.sv
// Bus bundle between a serial bit source / parallel word consumer and the shift register.
// The master drives control and data; the slave (the register) returns the word and status.
interface sipo_universal_shift_reg_if #(
  parameter int WIDTH = 8
) ();
  import sipo_pkg::*;

  localparam int CNT_W = cnt_width(WIDTH);

  logic             load;
  logic [WIDTH-1:0] d;
  logic             shift_en;
  logic             dir;
  logic             rotate;
  logic             serial_in;
  logic [WIDTH-1:0] q;
  logic             serial_out;
  logic             word_valid;
  logic [CNT_W-1:0] bit_cnt;

  modport master (
    output load, d, shift_en, dir, rotate, serial_in,
    input  q, serial_out, word_valid, bit_cnt
  );

  modport slave (
    input  load, d, shift_en, dir, rotate, serial_in,
    output q, serial_out, word_valid, bit_cnt
  );

endinterface

// File: rtl/sipo_universal_shift_reg_bit_counter.sv
// Counts shifts modulo WIDTH and pulses word_valid on the edge that completes a word.
// A clear (parallel load) abandons the partial word without a pulse.
module sipo_bit_counter
  import sipo_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             word_valid
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             wv_d, wv_q;

  always_comb begin
    cnt_d = cnt_q;
    wv_d  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        wv_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      wv_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      wv_q  <= wv_d;
    end
  end

  assign bit_cnt    = cnt_q;
  assign word_valid = wv_q;

endmodule

// File: rtl/sipo_universal_shift_reg.sv
// Parametrised universal shift register: parallel load, left/right shift or rotate,
// registered serial output, and a word counter that makes it a SIPO deserializer.
module sipo_universal_shift_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                        clk,
  input logic                        rst,
  sipo_universal_shift_reg_if.slave  bus
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             so_d, so_q;
  logic             in_bit;
  logic             cnt_inc;

  // The entering bit is the one leaving the opposite end when rotating, else serial_in.
  always_comb begin
    q_d    = q_q;
    so_d   = so_q;
    in_bit = bus.serial_in;
    if (bus.load) begin
      q_d = bus.d;
    end else if (bus.shift_en) begin
      if (bus.dir == DIR_RIGHT) begin
        in_bit = bus.rotate ? q_q[0] : bus.serial_in;
        so_d   = q_q[0];
        q_d    = {in_bit, q_q[WIDTH-1:1]};
      end else begin
        in_bit = bus.rotate ? q_q[WIDTH-1] : bus.serial_in;
        so_d   = q_q[WIDTH-1];
        q_d    = {q_q[WIDTH-2:0], in_bit};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q  <= '0;
      so_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      so_q <= so_d;
    end
  end

  assign cnt_inc = bus.shift_en & ~bus.load;

  sipo_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.load),
    .inc        (cnt_inc),
    .bit_cnt    (bus.bit_cnt),
    .word_valid (bus.word_valid)
  );

  assign bus.q          = q_q;
  assign bus.serial_out = so_q;

endmodule

// File: tb/tb_sipo_universal_shift_reg.sv
// Bench for sipo_universal_shift_reg: directed scenarios at WIDTH=4 and WIDTH=8,
// then randomized traffic checked against a word-level reference model.
module tb_sipo_universal_shift_reg;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sipo_universal_shift_reg_if #(.WIDTH(4)) bus4 ();
  sipo_universal_shift_reg_if #(.WIDTH(8)) bus8 ();

  sipo_universal_shift_reg #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  sipo_universal_shift_reg #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  // Apply one cycle of inputs to the 4-bit DUT and sample just after the edge.
  task automatic drive4(input logic ld, input logic [3:0] dv, input logic sh,
                        input logic dr, input logic rt, input logic si);
    bus4.load      = ld;
    bus4.d         = dv;
    bus4.shift_en  = sh;
    bus4.dir       = dr;
    bus4.rotate    = rt;
    bus4.serial_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic sh, input logic si);
    bus8.load      = 1'b0;
    bus8.d         = '0;
    bus8.shift_en  = sh;
    bus8.dir       = 1'b0;
    bus8.rotate    = 1'b0;
    bus8.serial_in = si;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus4.load = 0; bus4.d = '0; bus4.shift_en = 0; bus4.dir = 0; bus4.rotate = 0; bus4.serial_in = 0;
    bus8.load = 0; bus8.d = '0; bus8.shift_en = 0; bus8.dir = 0; bus8.rotate = 0; bus8.serial_in = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got;
    idle_all();
    rst = 1'b1;
    #2;
    got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
    checks++;
    if (got !== 8'b0) begin
      failures++;
      $display("[TB] FAIL reset_async4: got {q,so,cnt,wv}=%b want %b", got, 8'b0);
    end
    checks++;
    if ({bus8.q, bus8.serial_out, bus8.bit_cnt, bus8.word_valid} !== 13'b0) begin
      failures++;
      $display("[TB] FAIL reset_async8: got q=%b so=%b cnt=%0d wv=%b want all zero",
               bus8.q, bus8.serial_out, bus8.bit_cnt, bus8.word_valid);
    end
    bus4.load = 1'b1; bus4.d = 4'b1111; bus4.shift_en = 1'b1;
    @(posedge clk);
    #1;
    got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
    checks++;
    if (got !== 8'b0) begin
      failures++;
      $display("[TB] FAIL reset_held: got {q,so,cnt,wv}=%b want %b", got, 8'b0);
    end
    idle_all();
    rst = 1'b0;
  endtask

  task automatic test_load_shift_right();
    logic [7:0] exp_v [4];
    logic [7:0] got;
    // {q, serial_out, bit_cnt, word_valid}
    exp_v = '{8'b0011_0_01_0, 8'b0001_1_10_0, 8'b0000_1_11_0, 8'b0000_0_00_1};
    do_reset();
    drive4(1, 4'b0110, 0, 0, 0, 0);
    got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
    checks++;
    if (got !== 8'b0110_0_00_0) begin
      failures++;
      $display("[TB] FAIL load_0110: got %b want %b", got, 8'b0110_0_00_0);
    end
    for (int i = 0; i < 4; i++) begin
      drive4(0, 4'b0000, 1, 0, 0, 0);
      got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("[TB] FAIL shift_right step %0d: got %b want %b", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_deserialize();
    logic [7:0] exp_v [5];
    logic       sin_v [5];
    logic [7:0] got;
    exp_v = '{8'b1000_0_01_0, 8'b0100_0_10_0, 8'b1010_0_11_0, 8'b1101_0_00_1, 8'b0110_1_01_0};
    sin_v = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive4(0, 4'b0000, 1, 0, 0, sin_v[i]);
      got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("[TB] FAIL deserialize step %0d: got %b want %b", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_left_rotate();
    logic [7:0] exp_v [4];
    logic [7:0] got;
    exp_v = '{8'b0011_1_01_0, 8'b0110_0_10_0, 8'b1100_0_11_0, 8'b1001_1_00_1};
    do_reset();
    drive4(1, 4'b1001, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive4(0, 4'b0000, 1, 1, 1, 1);
      got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
      checks++;
      if (got !== exp_v[i]) begin
        failures++;
        $display("[TB] FAIL left_rotate step %0d: got %b want %b", i, got, exp_v[i]);
      end
    end
  endtask

  task automatic test_gaps_priority();
    logic [7:0] got;
    do_reset();
    drive4(0, 4'b0000, 1, 0, 0, 1);
    drive4(0, 4'b0000, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      drive4(0, 4'b0000, 0, 0, 0, 1);
      got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
      checks++;
      if (got !== 8'b1100_0_10_0) begin
        failures++;
        $display("[TB] FAIL idle_hold cycle %0d: got %b want %b", i, got, 8'b1100_0_10_0);
      end
    end
    drive4(1, 4'b1010, 1, 0, 0, 1);
    got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
    checks++;
    if (got !== 8'b1010_0_00_0) begin
      failures++;
      $display("[TB] FAIL load_over_shift: got %b want %b", got, 8'b1010_0_00_0);
    end
  endtask

  task automatic test_async_reset_midword();
    logic [7:0] got;
    do_reset();
    drive4(1, 4'b0111, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive4(0, 4'b0000, 1, 0, 0, 1);
    got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
    checks++;
    if (got !== 8'b1110_1_11_0) begin
      failures++;
      $display("[TB] FAIL midword_setup: got %b want %b", got, 8'b1110_1_11_0);
    end
    #2;
    rst = 1'b1;
    #1;
    got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
    checks++;
    if (got !== 8'b0) begin
      failures++;
      $display("[TB] FAIL midword_async_clear: got %b want %b", got, 8'b0);
    end
    for (int i = 0; i < 2; i++) begin
      drive4(0, 4'b0000, 1, 0, 0, 1);
      got = {bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid};
      checks++;
      if (got !== 8'b0) begin
        failures++;
        $display("[TB] FAIL midword_reset_held cycle %0d: got %b want %b", i, got, 8'b0);
      end
    end
    rst = 1'b0;
    idle_all();
  endtask

  task automatic test_width8();
    logic sin_v [8];
    sin_v = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive8(1, sin_v[i]);
      if (i < 7) begin
        checks++;
        if (bus8.word_valid !== 1'b0 || int'(bus8.bit_cnt) != i + 1) begin
          failures++;
          $display("[TB] FAIL w8_partial shift %0d: got wv=%b cnt=%0d want wv=0 cnt=%0d",
                   i + 1, bus8.word_valid, bus8.bit_cnt, i + 1);
        end
      end
    end
    checks++;
    if (bus8.q !== 8'b10000001 || bus8.word_valid !== 1'b1 || bus8.bit_cnt !== 3'd0) begin
      failures++;
      $display("[TB] FAIL w8_word: got q=%b wv=%b cnt=%0d want q=10000001 wv=1 cnt=0",
               bus8.q, bus8.word_valid, bus8.bit_cnt);
    end
    drive8(0, 0);
    checks++;
    if (bus8.word_valid !== 1'b0 || bus8.q !== 8'b10000001) begin
      failures++;
      $display("[TB] FAIL w8_single_pulse: got q=%b wv=%b want q=10000001 wv=0",
               bus8.q, bus8.word_valid);
    end
  endtask

  // Reference model: word value as an integer, shift count tracked modulo the width.
  task automatic test_random();
    int         m_q, m_cnt, shifts_total;
    logic       m_so, m_wv, ld, sh, dr, rt, si, out_bit, in_bit;
    logic [3:0] dv;
    do_reset();
    m_q = 0; m_so = 0; m_cnt = 0; m_wv = 0; shifts_total = 0;
    for (int n = 0; n < 400; n++) begin
      ld = ($urandom_range(0, 9) == 0);
      sh = ($urandom_range(0, 3) != 0);
      dr = 1'($urandom);
      rt = ($urandom_range(0, 3) == 0);
      si = 1'($urandom);
      dv = 4'($urandom);
      drive4(ld, dv, sh, dr, rt, si);
      m_wv = 0;
      if (ld) begin
        m_q   = dv;
        m_cnt = 0;
      end else if (sh) begin
        if (dr == 1'b0) begin
          out_bit = 1'(m_q % 2);
          in_bit  = rt ? out_bit : si;
          m_q     = m_q / 2 + (in_bit ? 8 : 0);
        end else begin
          out_bit = 1'(m_q / 8);
          in_bit  = rt ? out_bit : si;
          m_q     = (m_q * 2) % 16 + (in_bit ? 1 : 0);
        end
        m_so  = out_bit;
        m_cnt = (m_cnt + 1) % 4;
        m_wv  = (m_cnt == 0);
        shifts_total++;
      end
      checks++;
      if (int'(bus4.q) != m_q || bus4.serial_out !== m_so ||
          int'(bus4.bit_cnt) != m_cnt || bus4.word_valid !== m_wv) begin
        failures++;
        $display("[TB] FAIL random cycle %0d: got q=%b so=%b cnt=%0d wv=%b want q=%b so=%b cnt=%0d wv=%b",
                 n, bus4.q, bus4.serial_out, bus4.bit_cnt, bus4.word_valid,
                 4'(m_q), m_so, m_cnt, m_wv);
      end
    end
    $display("[TB] random phase applied %0d shifts", shifts_total);
  endtask

  initial begin
    test_reset();
    test_load_shift_right();
    test_deserialize();
    test_left_rotate();
    test_gaps_priority();
    test_async_reset_midword();
    test_width8();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
